// File: rtl/ppm_pkg.sv
// Shared definitions for the sppm link: FSM state codes, frame length helper,
// and the default link timing used by both the transmitter and the receiver bench.
// No logic; constants and a pure function only.
package ppm_pkg;

    // Transmitter FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLOT  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Default link timing (500 MHz domain)
    localparam int DEF_SLOT_BITS    = 2;
    localparam int DEF_SLOT_CYCLES  = 4;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_GUARD_SLOTS  = 1;
    localparam int DEF_CNT_W        = 16;

    // Frame length in clock cycles: (data slots + guard slots) * cycles per slot
    function automatic int frame_len(input int slot_bits, input int slot_cycles,
                                     input int guard_slots);
        return ((1 << slot_bits) + guard_slots) * slot_cycles;
    endfunction

    localparam int DEF_FRAME_LEN = frame_len(DEF_SLOT_BITS, DEF_SLOT_CYCLES, DEF_GUARD_SLOTS);

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle-within-slot and slot-within-frame counters for the PPM transmitter.
// Latency: counters load 0/0 on the edge after i_start; next-values exposed combinationally.
// No backpressure; advances every cycle while i_run is high.
module ppm_slot_timer #(
    parameter int SLOT_CYCLES = 4,
    parameter int NUM_SLOTS   = 5,
    parameter int CYC_W       = 2,
    parameter int SLOT_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_run,
    output logic [CYC_W-1:0]  o_cyc_nxt,
    output logic [SLOT_W-1:0] o_slot,
    output logic [SLOT_W-1:0] o_slot_nxt,
    output logic              o_last_slot_cyc,
    output logic              o_last_frame_cyc
);

    logic [CYC_W-1:0]  r_cyc;
    logic [SLOT_W-1:0] r_slot;
    logic              w_last_slot_cyc;
    logic              w_last_frame_cyc;

    assign w_last_slot_cyc  = (r_cyc == CYC_W'(SLOT_CYCLES - 1));
    assign w_last_frame_cyc = w_last_slot_cyc && (r_slot == SLOT_W'(NUM_SLOTS - 1));

    // Next counter values: a start (or reset) restarts the frame, otherwise step while running
    always_comb begin
        o_cyc_nxt  = r_cyc;
        o_slot_nxt = r_slot;
        if (rst || i_start) begin
            o_cyc_nxt  = '0;
            o_slot_nxt = '0;
        end else if (i_run) begin
            if (w_last_slot_cyc) begin
                o_cyc_nxt  = '0;
                o_slot_nxt = w_last_frame_cyc ? '0 : r_slot + SLOT_W'(1);
            end else begin
                o_cyc_nxt  = r_cyc + CYC_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        r_cyc  <= o_cyc_nxt;
        r_slot <= o_slot_nxt;
    end

    assign o_slot           = r_slot;
    assign o_last_slot_cyc  = w_last_slot_cyc;
    assign o_last_frame_cyc = w_last_frame_cyc;

endmodule

// File: rtl/ppm_tx.sv
// PPM transmitter: one pulse per frame in the slot selected by the symbol, then guard slots.
// Latency: frame starts (frame_start, first cycle of slot 0) the cycle after the accepting handshake.
// Backpressure: sym_ready only in IDLE or the final cycle of a frame; otherwise symbols wait.
module ppm_tx
    import ppm_pkg::*;
#(
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GUARD_SLOTS  = DEF_GUARD_SLOTS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SLOT_BITS-1:0] sym_data,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    output logic                 sppm,
    output logic                 frame_start,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int M         = 1 << SLOT_BITS;
    localparam int NUM_SLOTS = M + GUARD_SLOTS;
    localparam int CYC_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    // One extra bit so PULSE_CYCLES == SLOT_CYCLES (a power of two) stays representable
    localparam logic [CYC_W:0] PULSE_LIM = (CYC_W + 1)'(PULSE_CYCLES);

    if (SLOT_BITS < 1) begin : g_chk_slot_bits
        $error("ppm_tx: SLOT_BITS must be at least 1");
    end
    if (SLOT_CYCLES < 1) begin : g_chk_slot_cycles
        $error("ppm_tx: SLOT_CYCLES must be at least 1");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > SLOT_CYCLES) begin : g_chk_pulse
        $error("ppm_tx: PULSE_CYCLES must lie in 1..SLOT_CYCLES");
    end
    if (GUARD_SLOTS < 0) begin : g_chk_guard
        $error("ppm_tx: GUARD_SLOTS must be non-negative");
    end

    logic [1:0]           r_state;
    logic [SLOT_BITS-1:0] r_sym_q;
    logic                 r_sppm;
    logic                 r_frame_start;
    logic [CNT_W-1:0]     r_frame_cnt;

    logic [1:0]           w_state_nxt;
    logic [SLOT_BITS-1:0] w_sym_nxt;
    logic [CYC_W-1:0]     w_cyc_nxt;
    logic [SLOT_W-1:0]    w_slot;
    logic [SLOT_W-1:0]    w_slot_nxt;
    logic                 w_last_slot;
    logic                 w_last_frame;
    logic                 w_rdy;
    logic                 w_xfer;
    logic                 w_pulse_nxt;

    ppm_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_SLOTS   (NUM_SLOTS),
        .CYC_W       (CYC_W),
        .SLOT_W      (SLOT_W)
    ) u_timer (
        .clk              (clk),
        .rst              (rst),
        .i_start          (w_xfer),
        .i_run            (r_state != ST_IDLE),
        .o_cyc_nxt        (w_cyc_nxt),
        .o_slot           (w_slot),
        .o_slot_nxt       (w_slot_nxt),
        .o_last_slot_cyc  (w_last_slot),
        .o_last_frame_cyc (w_last_frame)
    );

    // Ready is a pure function of state and reset, never of sym_valid
    assign w_rdy     = ~rst & ((r_state == ST_IDLE) | w_last_frame);
    assign w_xfer    = sym_valid & w_rdy;
    assign w_sym_nxt = w_xfer ? sym_data : r_sym_q;

    // Next FSM state; the frame-end check comes first so GUARD_SLOTS=0 bypasses GUARD
    always_comb begin
        w_state_nxt = r_state;
        if (rst) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) w_state_nxt = ST_SLOT;
                end
                ST_SLOT, ST_GUARD: begin
                    if (w_last_frame)
                        w_state_nxt = w_xfer ? ST_SLOT : ST_IDLE;
                    else if (r_state == ST_SLOT && w_last_slot && w_slot == SLOT_W'(M - 1))
                        w_state_nxt = ST_GUARD;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pulse decision made on next-cycle values so sppm comes straight from a flop
    assign w_pulse_nxt = (w_state_nxt == ST_SLOT) &&
                         (w_slot_nxt == SLOT_W'(w_sym_nxt)) &&
                         ({1'b0, w_cyc_nxt} < PULSE_LIM);

    // State, held symbol, registered outputs and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sym_q       <= '0;
            r_sppm        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sym_q       <= w_sym_nxt;
            r_sppm        <= w_pulse_nxt;
            r_frame_start <= w_xfer;
            if (w_xfer) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    assign sym_ready   = w_rdy;
    assign sppm        = r_sppm;
    assign frame_start = r_frame_start;
    assign busy        = (r_state != ST_IDLE);
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ppm_tx.sv
// Bench for ppm_tx: two instances (default timing, and full-slot pulse / no guard / 4-bit counter)
// share one stimulus stream and are each checked every cycle against a frame-offset model.
// Directed steps cover single frame, back-to-back, backpressure, mid-pulse reset and wrap, then random.
module tb_ppm_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_data = 2'd0;

    logic        rdy0, sppm0, fs0, busy0;
    logic [15:0] cnt0;
    logic        rdy1, sppm1, fs1, busy1;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    ppm_tx #(.SLOT_BITS(2), .SLOT_CYCLES(4), .PULSE_CYCLES(2), .GUARD_SLOTS(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(rdy0),
        .sppm(sppm0), .frame_start(fs0), .busy(busy0), .frame_cnt(cnt0));

    ppm_tx #(.SLOT_BITS(2), .SLOT_CYCLES(4), .PULSE_CYCLES(4), .GUARD_SLOTS(0), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(rdy1),
        .sppm(sppm1), .frame_start(fs1), .busy(busy1), .frame_cnt(cnt1));

    // Model parameters per instance: frame length, slot cycles, pulse cycles, counter width
    int F_LEN [2] = '{20, 16};
    int SC    [2] = '{4, 4};
    int PC    [2] = '{2, 4};
    int CWID  [2] = '{16, 4};

    // Model state: in-frame flag, offset within frame, held symbol, frame count, strobe
    bit m_act  [2];
    int m_k    [2];
    int m_sym  [2];
    int m_cnt  [2];
    bit m_fs   [2];
    bit m_xfer [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit exp_rdy(input int i, input logic r);
        return !r && (!m_act[i] || m_k[i] == F_LEN[i] - 1);
    endfunction

    function automatic bit exp_pulse(input int i);
        return m_act[i] && (m_k[i] / SC[i] == m_sym[i]) && (m_k[i] % SC[i] < PC[i]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u0.sym_ready",   32'(rdy0),  32'(exp_rdy(0, rst)));
        chk("u0.sppm",        32'(sppm0), 32'(exp_pulse(0)));
        chk("u0.frame_start", 32'(fs0),   32'(m_fs[0]));
        chk("u0.busy",        32'(busy0), 32'(m_act[0]));
        chk("u0.frame_cnt",   32'(cnt0),  32'(m_cnt[0]));
        chk("u1.sym_ready",   32'(rdy1),  32'(exp_rdy(1, rst)));
        chk("u1.sppm",        32'(sppm1), 32'(exp_pulse(1)));
        chk("u1.frame_start", 32'(fs1),   32'(m_fs[1]));
        chk("u1.busy",        32'(busy1), 32'(m_act[1]));
        chk("u1.frame_cnt",   32'(cnt1),  32'(m_cnt[1]));
    endtask

    // Advance one instance's model across a clock edge using the inputs held at that edge
    task automatic step(input int i);
        bit x;
        x = sym_valid && exp_rdy(i, rst);
        if (rst) begin
            m_act[i] = 1'b0; m_cnt[i] = 0; m_fs[i] = 1'b0; x = 1'b0;
        end else if (x) begin
            m_act[i] = 1'b1; m_k[i] = 0; m_sym[i] = int'(sym_data);
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CWID[i]);
            m_fs[i]  = 1'b1;
        end else begin
            m_fs[i] = 1'b0;
            if (m_act[i]) begin
                m_k[i]++;
                if (m_k[i] == F_LEN[i]) m_act[i] = 1'b0;
            end
        end
        m_xfer[i] = x;
    endtask

    // One clock cycle: drive on the falling edge, check, then step the model over the rising edge
    task automatic cyc(input logic r, input logic v, input logic [1:0] d);
        @(negedge clk);
        rst = r; sym_valid = v; sym_data = d;
        #1;
        check_all();
        @(posedge clk);
        step(0);
        step(1);
    endtask

    initial begin
        int n;
        int idx;
        logic [1:0] syms [3];
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_sym[i] = 0; m_cnt[i] = 0; m_fs[i] = 1'b0; m_xfer[i] = 1'b0;
        end

        // Reset held for a few cycles
        repeat (3) cyc(1'b1, 1'b0, 2'd0);

        // Single symbol 2 after an idle stretch, then let the frame run out
        repeat (10) cyc(1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 2'd2);
        repeat (25) cyc(1'b0, 1'b0, 2'($urandom));

        // Back-to-back symbols 0,3,1 with valid held high
        syms[0] = 2'd0; syms[1] = 2'd3; syms[2] = 2'd1;
        idx = 0; n = 0;
        while (idx < 3 && n < 100) begin
            cyc(1'b0, 1'b1, syms[idx]);
            if (m_xfer[0]) idx++;
            n++;
        end
        chk("t2.all_accepted", 32'(idx), 32'd3);
        repeat (25) cyc(1'b0, 1'b0, 2'd0);

        // Backpressure: valid from offset 5 with data churning, accepted only at offset 19
        cyc(1'b0, 1'b1, 2'd1);
        repeat (5) cyc(1'b0, 1'b0, 2'($urandom));
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 2'($urandom));
            n++;
        end while (!m_xfer[0] && n < 40);
        chk("t3.accept_wait", 32'(n), 32'd15);
        repeat (25) cyc(1'b0, 1'b0, 2'($urandom));

        // Reset asserted while sppm is high, then a clean frame right after
        cyc(1'b0, 1'b1, 2'd3);
        n = 0;
        while (!exp_pulse(0) && n < 40) begin
            cyc(1'b0, 1'b0, 2'd0);
            n++;
        end
        chk("t4.pulse_seen", 32'(n < 40), 32'd1);
        cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 2'd2);
        repeat (25) cyc(1'b0, 1'b0, 2'd0);

        // 17 consecutive frames on the 4-bit counter instance
        cyc(1'b1, 1'b0, 2'd0);
        repeat (17 * 16) cyc(1'b0, 1'b1, 2'd3);
        @(negedge clk);
        #1;
        chk("t5.wrap_cnt", 32'(cnt1), 32'd1);
        @(posedge clk);
        step(0);
        step(1);

        // Random traffic with occasional resets
        repeat (1500) cyc(($urandom % 300) == 0, ($urandom % 4) != 0, 2'($urandom));
        repeat (25) cyc(1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
